uart_tx: RTL and testbench
==========================

Name: uart_tx

Overview:
- Serial UART transmitter.
- Takes one parallel byte on a single-cycle start request and shifts it out on one line as a standard asynchronous frame: start bit, 8 data bits LSB first, optional parity bit, one stop bit.
- Sits between a host/control block issuing bytes and the physical TX pin.
- Reports occupancy through tx_busy.

Parameters:
- CLKS_PER_BIT, 16, clock cycles per serial bit (baud divisor); legal range >= 2.

Ports:
- clk  input  1  system clock; all state changes on rising edge.
- rst_n  input  1  asynchronous active-low reset.
- tx_start  input  1  transmit request, sampled on rising edge of clk.
- data_in  input  8  byte to transmit, captured with tx_start.
- parity_en  input  1  1 = append parity bit; captured with tx_start.
- even_parity  input  1  1 = even parity, 0 = odd parity; captured with tx_start, ignored when parity_en=0.
- tx  output  1  serial line, idle high; registered output.
- tx_busy  output  1  high while a frame is in progress; registered output.

Behaviour:
- Clocking and reset: one clock; reset is asynchronous and active-low.
  - rst_n=0 immediately forces tx=1, tx_busy=0, FSM=IDLE, bit counter=0, baud counter=0.
  - Reset mid-frame aborts the frame; the line returns high at once.
- FSM states: IDLE, START, DATA, PARITY, STOP.
- IDLE:
  - tx=1, tx_busy=0.
  - On a rising edge with tx_start=1: latch data_in, parity_en, even_parity into internal registers and go to START.
  - Starting from the cycle after that edge, tx=0 and tx_busy=1.
- Each serial bit is held for exactly CLKS_PER_BIT cycles, timed by a baud counter that is cleared at every bit boundary.
- START: tx=0 for CLKS_PER_BIT cycles, then DATA.
- DATA:
  - tx = latched data bit[i], i = 0..7, LSB first, each CLKS_PER_BIT cycles.
  - After bit 7, go to PARITY if the latched parity_en=1, else STOP.
- PARITY:
  - tx = ^data when even_parity=1; tx = ~^data when even_parity=0.
  - Computed from the latched byte and latched flags.
  - Lasts CLKS_PER_BIT cycles, then STOP.
- STOP: tx=1 for CLKS_PER_BIT cycles, then IDLE; tx_busy drops to 0 on that same transition.
- Frame length: tx_busy high for exactly 10*CLKS_PER_BIT cycles without parity, 11*CLKS_PER_BIT with parity.
- tx_start while tx_busy=1 is ignored: not queued, and it does not restart the frame.
- Changes on data_in, parity_en, even_parity during a frame have no effect on that frame.
- Back-to-back frames:
  - A tx_start sampled on the first IDLE edge (the edge after tx_busy falls) is accepted.
  - Minimum inter-frame gap: 1 cycle of tx=1 beyond the stop bit.
- tx_start held high continuously produces consecutive frames of the same byte, each separated by the 1-cycle IDLE gap.
- tx and tx_busy are glitch-free registered outputs; no combinational path from inputs to outputs.
- Counter widths: baud counter holds 0..CLKS_PER_BIT-1; bit index holds 0..7.

Test Plan:
- Reset: assert rst_n=0 mid-frame (during DATA bit 3) -> tx=1 and tx_busy=0 immediately; after release, IDLE until next tx_start.
- No parity: data_in=0xA5, parity_en=0, one-cycle tx_start -> tx sequence 0,1,0,1,0,0,1,0,1,1, each bit 16 cycles; tx_busy high exactly 160 cycles.
- Even parity: data_in=0x07, parity_en=1, even_parity=1 -> data bits 1,1,1,0,0,0,0,0, parity bit 1, stop 1; tx_busy high 176 cycles. Repeat with 0xA5 -> parity bit 0.
- Odd parity: data_in=0xA5, parity_en=1, even_parity=0 -> parity bit 1; data_in=0x00 -> parity bit 1; data_in=0xFF -> parity bit 1.
- Busy protection: start 0x3C, then pulse tx_start with data_in=0xFF and toggle parity_en mid-frame -> frame still transmits 0x3C with original parity setting; no second frame follows.
- Back-to-back and random: hold tx_start high with 0x55 -> two consecutive frames with exactly a 1-cycle idle-high gap. Then run 20 random frames (random byte, parity_en, even_parity) against a reference model that samples tx mid-bit -> every decoded byte and parity bit matches, and stop bit = 1.

Source files
------------

// File: rtl/uart_tx.sv
// uart_tx: serial UART transmitter.
//
// This block accepts one byte on a single-cycle start request. It sends the
// byte on the tx line as an asynchronous frame in this order:
//   start bit (0), data[0] .. data[7], an optional parity bit, stop bit (1).
//
// Ports:
//   clk          system clock; all state changes happen on the rising edge
//   rst_n        asynchronous active-low reset
//   tx_start     transmit request; accepted only while idle
//   data_in      byte to send; captured when the request is accepted
//   parity_en    1 = add a parity bit; captured when the request is accepted
//   even_parity  1 = even parity, 0 = odd parity; captured when the request
//                is accepted
//   tx           registered serial line; high when idle
//   tx_busy      registered; high for the whole frame
//
// Handshake: tx_start is sampled on each rising edge. A request is taken
// only when the FSM is idle, which is exactly when tx_busy is low. Requests
// made while tx_busy is high are dropped and are not queued. If tx_start is
// held high, a new frame starts on every first idle edge. Each pair of frames
// is then separated by one cycle of idle-high line.
//
// The FSM state is held in state_q. Bind checkers to this signal.

module uart_tx #(
  parameter int CLKS_PER_BIT = 16
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       tx_start,
  input  logic [7:0] data_in,
  input  logic       parity_en,
  input  logic       even_parity,
  output logic       tx,
  output logic       tx_busy
);

  localparam int BW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [BW-1:0] BAUD_LAST = BW'(CLKS_PER_BIT - 1);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_START  = 3'd1,
    S_DATA   = 3'd2,
    S_PARITY = 3'd3,
    S_STOP   = 3'd4
  } state_t;

  state_t        state_q, state_d;
  logic [BW-1:0] baud_q, baud_d;
  logic [2:0]    bit_q, bit_d;
  logic [7:0]    data_q, data_d;
  logic          par_en_q, par_en_d;
  logic          even_q, even_d;
  logic          tx_d, busy_d;
  logic          bit_done;

  // High on the last clock of the bit currently being sent.
  assign bit_done = (baud_q == BAUD_LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      baud_q   <= '0;
      bit_q    <= '0;
      data_q   <= '0;
      par_en_q <= 1'b0;
      even_q   <= 1'b0;
      tx       <= 1'b1;
      tx_busy  <= 1'b0;
    end else begin
      state_q  <= state_d;
      baud_q   <= baud_d;
      bit_q    <= bit_d;
      data_q   <= data_d;
      par_en_q <= par_en_d;
      even_q   <= even_d;
      tx       <= tx_d;
      tx_busy  <= busy_d;
    end
  end

  // Next-state logic. The baud counter returns to zero at every bit
  // boundary, so each bit lasts exactly CLKS_PER_BIT cycles.
  always_comb begin
    state_d  = state_q;
    baud_d   = baud_q;
    bit_d    = bit_q;
    data_d   = data_q;
    par_en_d = par_en_q;
    even_d   = even_q;

    case (state_q)
      S_IDLE: begin
        baud_d = '0;
        bit_d  = '0;
        if (tx_start) begin
          state_d  = S_START;
          data_d   = data_in;
          par_en_d = parity_en;
          even_d   = even_parity;
        end
      end
      S_START: begin
        if (bit_done) begin
          state_d = S_DATA;
          baud_d  = '0;
          bit_d   = '0;
        end else begin
          baud_d = baud_q + 1'b1;
        end
      end
      S_DATA: begin
        if (bit_done) begin
          baud_d = '0;
          if (bit_q == 3'd7) begin
            state_d = par_en_q ? S_PARITY : S_STOP;
            bit_d   = '0;
          end else begin
            bit_d = bit_q + 3'd1;
          end
        end else begin
          baud_d = baud_q + 1'b1;
        end
      end
      S_PARITY: begin
        if (bit_done) begin
          state_d = S_STOP;
          baud_d  = '0;
        end else begin
          baud_d = baud_q + 1'b1;
        end
      end
      S_STOP: begin
        if (bit_done) begin
          state_d = S_IDLE;
          baud_d  = '0;
        end else begin
          baud_d = baud_q + 1'b1;
        end
      end
      default: begin
        state_d = S_IDLE;
        baud_d  = '0;
        bit_d   = '0;
      end
    endcase
  end

  // The outputs are decoded from the next state and then registered. This
  // makes tx and tx_busy change on the same edge as the state, and there is
  // no combinational path from the inputs to the pins.
  always_comb begin
    tx_d   = 1'b1;
    busy_d = 1'b1;
    case (state_d)
      S_IDLE:   busy_d = 1'b0;
      S_START:  tx_d   = 1'b0;
      S_DATA:   tx_d   = data_d[bit_d];
      S_PARITY: tx_d   = even_d ? (^data_d) : ~(^data_d);
      S_STOP:   tx_d   = 1'b1;
      default: begin
        tx_d   = 1'b1;
        busy_d = 1'b0;
      end
    endcase
  end

endmodule

// File: tb/tb_uart_tx.sv
// Testbench for uart_tx.
//
// The driver sends bytes into the design. For each byte it pushes the
// expected frame into exp_q and the expected busy length into len_q.
// Two independent monitors decode tx and measure tx_busy, and they compare
// what they see against those queues.

module tb_uart_tx;

  localparam int N = 16;

  logic       clk;
  logic       rst_n;
  logic       tx_start;
  logic [7:0] data_in;
  logic       parity_en;
  logic       even_parity;
  logic       tx;
  logic       tx_busy;

  // Expected frame layout: {parity_en, parity_bit, data byte}.
  logic [9:0] exp_q[$];
  int         len_q[$];
  int         total;
  int         bad;
  logic       mon_en;

  uart_tx #(.CLKS_PER_BIT(N)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .tx_start   (tx_start),
    .data_in    (data_in),
    .parity_en  (parity_en),
    .even_parity(even_parity),
    .tx         (tx),
    .tx_busy    (tx_busy)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- reference model and checking ----------------
  function automatic logic ref_parity(input logic [7:0] d, input logic even);
    int ones;
    ones = $countones(d);
    // Even parity makes the total number of ones even; odd makes it odd.
    return even ? logic'(ones % 2) : logic'((ones + 1) % 2);
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic wait_idle();
    int n;
    n = 0;
    @(negedge clk);
    while (tx_busy && n < 20 * N) begin
      @(negedge clk);
      n++;
    end
    check("idle_timeout", {31'd0, tx_busy}, 32'd0);
  endtask

  task automatic send(input logic [7:0] d, input logic pe, input logic ep, input bit push);
    wait_idle();
    if (push) begin
      exp_q.push_back({pe, ref_parity(d, ep), d});
      len_q.push_back(pe ? 11 * N : 10 * N);
    end
    data_in     = d;
    parity_en   = pe;
    even_parity = ep;
    tx_start    = 1'b1;
    @(negedge clk);
    tx_start    = 1'b0;
  endtask

  // ---------------- monitor: decode tx and compare with exp_q ----------------
  initial begin
    logic [7:0] got;
    logic [9:0] e;
    forever begin
      @(negedge clk);
      if (mon_en && rst_n && tx === 1'b0) begin
        // This sample is the first cycle of the start bit. Move to the
        // middle of each bit before sampling it.
        repeat (N / 2) @(negedge clk);
        check("start_bit", {31'd0, tx}, 32'd0);
        for (int i = 0; i < 8; i++) begin
          repeat (N) @(negedge clk);
          got[i] = tx;
        end
        if (exp_q.size() == 0) begin
          check("unexpected_frame", 32'd1, 32'd0);
          e = {2'b00, got};
        end else begin
          e = exp_q.pop_front();
          check("data_byte", {24'd0, got}, {24'd0, e[7:0]});
        end
        if (e[9]) begin
          repeat (N) @(negedge clk);
          check("parity_bit", {31'd0, tx}, {31'd0, e[8]});
        end
        repeat (N) @(negedge clk);
        check("stop_bit", {31'd0, tx}, 32'd1);
      end
    end
  end

  // ---------------- monitor: length of each tx_busy pulse ----------------
  initial begin
    int run;
    run = 0;
    forever begin
      @(negedge clk);
      if (!mon_en || !rst_n) begin
        run = 0;
      end else if (tx_busy) begin
        run++;
      end else if (run > 0) begin
        if (len_q.size() == 0) check("unexpected_busy", run, 32'd0);
        else check("busy_len", run, len_q.pop_front());
        run = 0;
      end
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    int n;
    logic [7:0] rb;
    total       = 0;
    bad         = 0;
    mon_en      = 1'b0;
    rst_n       = 1'b0;
    tx_start    = 1'b0;
    data_in     = 8'h00;
    parity_en   = 1'b0;
    even_parity = 1'b0;
    repeat (3) @(negedge clk);
    check("reset_tx", {31'd0, tx}, 32'd1);
    check("reset_busy", {31'd0, tx_busy}, 32'd0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // Reset in the middle of a frame, during data bit 3.
    send(8'hA5, 1'b0, 1'b0, 1'b0);
    repeat (4 * N + N / 2 - 1) @(negedge clk);
    check("pre_reset_busy", {31'd0, tx_busy}, 32'd1);
    #1 rst_n = 1'b0;
    #1;
    check("async_reset_tx", {31'd0, tx}, 32'd1);
    check("async_reset_busy", {31'd0, tx_busy}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3 * N) @(negedge clk);
    check("post_reset_tx", {31'd0, tx}, 32'd1);
    check("post_reset_busy", {31'd0, tx_busy}, 32'd0);
    mon_en = 1'b1;

    // Directed frames: no parity, even parity, and odd parity.
    send(8'hA5, 1'b0, 1'b0, 1'b1);
    send(8'h07, 1'b1, 1'b1, 1'b1);
    send(8'hA5, 1'b1, 1'b1, 1'b1);
    send(8'hA5, 1'b1, 1'b0, 1'b1);
    send(8'h00, 1'b1, 1'b0, 1'b1);
    send(8'hFF, 1'b1, 1'b0, 1'b1);

    // Busy protection: requests and input changes in mid-frame are ignored.
    send(8'h3C, 1'b1, 1'b1, 1'b1);
    repeat (3 * N) @(negedge clk);
    data_in   = 8'hFF;
    parity_en = 1'b0;
    tx_start  = 1'b1;
    @(negedge clk);
    tx_start  = 1'b0;
    repeat (2 * N) @(negedge clk);
    parity_en   = 1'b1;
    even_parity = 1'b0;
    wait_idle();
    repeat (3 * N) @(negedge clk);
    check("no_second_frame", {31'd0, tx_busy}, 32'd0);

    // Back to back: tx_start held high gives a one-cycle idle gap.
    exp_q.push_back({1'b0, ref_parity(8'h55, 1'b0), 8'h55});
    exp_q.push_back({1'b0, ref_parity(8'h55, 1'b0), 8'h55});
    len_q.push_back(10 * N);
    len_q.push_back(10 * N);
    data_in   = 8'h55;
    parity_en = 1'b0;
    tx_start  = 1'b1;
    @(negedge clk);
    n = 0;
    while (tx_busy && n < 20 * N) begin
      @(negedge clk);
      n++;
    end
    check("gap_busy_low", {31'd0, tx_busy}, 32'd0);
    check("gap_tx_high", {31'd0, tx}, 32'd1);
    @(negedge clk);
    check("gap_one_cycle_busy", {31'd0, tx_busy}, 32'd1);
    check("gap_one_cycle_start", {31'd0, tx}, 32'd0);
    tx_start = 1'b0;

    // Random frames.
    for (int k = 0; k < 20; k++) begin
      rb = 8'($urandom_range(0, 255));
      send(rb, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'b1);
      repeat ($urandom_range(0, 3)) @(negedge clk);
    end

    wait_idle();
    repeat (2 * N) @(negedge clk);
    check("frames_left", exp_q.size(), 32'd0);
    check("lengths_left", len_q.size(), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
